multicycle_sequencer: RTL and testbench
=======================================

Name: multicycle_sequencer

Overview:
- Multi-cycle FSM that drives the 8-bit core's datapath through fetch, decode, execute, memory and writeback phases.
- Produces per-phase enables (IR load, PC update, register write, data-memory strobes) from the 3-bit opcode.
- Performs a req/ack handshake with data memory, with a watchdog timeout.
- Counts retired instructions and stops cleanly on a halt request at an instruction boundary.

Parameters:
CNT_W, 16, width of retired-instruction counter
MEM_TIMEOUT, 15, max cycles in MEM without dmem_ack before fault (1..2^TO_W-1)
TO_W, 4, width of memory wait counter

Ports:
CLK  in  1  clock, all state updates on rising edge
reset_n  in  1  synchronous active-low reset
start  in  1  begin program at PC 0; honoured only in IDLE/DONE
halt_req  in  1  stop after current instruction retires
opcode  in  3  IR[8:6]; 0 sb, 1 lb, 2 add, 3 and, 4 xor, 5 cpy, 6 sl, 7 bne
branch_taken  in  1  bne compare result, valid in EXEC
dmem_ack  in  1  data memory completion
step  in  1  single-step advance (see Optional Feature)
pc_clr  out  1  clear PC
ir_load  out  1  latch instruction register
pc_inc  out  1  PC <= PC+1
pc_branch  out  1  PC <= branch target
reg_we  out  1  register-file write
dmem_req  out  1  data memory request
dmem_we  out  1  1 = store, qualifies dmem_req
busy  out  1  high in FETCH..WB (and PAUSE)
done  out  1  high in DONE
fault  out  1  high in FAULT
instr_count  out  CNT_W  retired instructions since last start

Behaviour:
- Reset: state IDLE; instr_count=0, wait counter=0; all outputs 0. Reset mid-instruction aborts it, and dmem_req is low from the next cycle.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, DONE, FAULT (+PAUSE with option).
- IDLE/DONE:
  - start=1 asserts pc_clr that cycle, clears instr_count and goes to FETCH.
  - start=0 stays put.
- FETCH: ir_load=1; go to DECODE.
- DECODE: one cycle, opcode now stable; go to EXEC.
- EXEC:
  - opcode 0/1 goes to MEM, wait counter cleared.
  - opcode 2-6 goes to WB.
  - opcode 7 retires here: pc_branch=branch_taken, pc_inc=!branch_taken.
- MEM:
  - dmem_req=1; dmem_we=1 iff opcode=0. Hold both stable until ack.
  - dmem_ack=1: sb retires (pc_inc=1 same cycle); lb goes to WB.
  - No ack: wait counter increments. When the counter equals MEM_TIMEOUT with ack still low, go to FAULT.
  - Ack arriving on the timeout cycle wins and there is no fault.
- WB: reg_we=1, pc_inc=1; retire.
- Retire cycle:
  - instr_count increments, wrapping at 2^CNT_W.
  - halt_req=1 goes to DONE; otherwise go to FETCH.
  - halt_req is sampled only on retire cycles.
- FAULT: fault=1, all strobes 0. Sticky until reset; start is ignored.
- Latency in cycles (n = MEM cycles including the ack cycle, n≥1): bne 3; add/and/xor/cpy/sl 4; sb 3+n; lb 4+n.
- dmem_ack outside MEM is ignored. start while busy is ignored.
- Output decode:
  - Mealy on inputs: pc_clr (start), pc_branch/pc_inc in EXEC (branch_taken), pc_inc in MEM (dmem_ack).
  - Moore: all other outputs are decoded from state.

Optional Feature:
- Macro SEQ_SINGLE_STEP_EN.
- Defined: every retire enters PAUSE instead of FETCH/DONE (busy=1, strobes 0).
  - step=1 in PAUSE goes to FETCH, or to DONE if halt_req was latched at retire.
  - halt_req latched at retire is kept through PAUSE.
- Undefined: PAUSE does not exist, step is ignored, and retire goes directly to FETCH/DONE.

Test Plan:
- Reset, start pulse, opcode=2 for 3 instructions with halt_req high on the 3rd retire -> pc_clr once; ir_load at cycles 1, 5, 9; reg_we at cycles 4, 8, 12; done at cycle 13; instr_count=3.
- opcode=7: branch_taken=1 -> pc_branch=1 and pc_inc=0 on the EXEC cycle, 3-cycle instruction. branch_taken=0 -> pc_inc=1.
- opcode=1, dmem_ack held low 3 cycles then high -> dmem_req high 4 cycles, dmem_we=0; reg_we 1 cycle later; total 8 cycles.
- opcode=0 with ack never asserted, MEM_TIMEOUT=15 -> fault=1 after 15 MEM cycles, dmem_req=0; a subsequent start is ignored; reset_n=0 returns to IDLE with fault=0.
- reset_n=0 while in MEM with dmem_req=1 -> next cycle IDLE, dmem_req=0, instr_count=0. start pulsed in FETCH -> no effect.
- SEQ_SINGLE_STEP_EN defined, opcode=3 -> PAUSE after retire (busy=1, no ir_load) until step=1; then FETCH on the next cycle.

Source files
------------

// File: rtl/multicycle_sequencer_if.sv
// Data-memory request/acknowledge handshake between the sequencer (master)
// and the data memory (slave).
interface multicycle_sequencer_if;
  logic dmem_req;
  logic dmem_we;
  logic dmem_ack;

  modport master (
    output dmem_req,
    output dmem_we,
    input  dmem_ack
  );

  modport slave (
    input  dmem_req,
    input  dmem_we,
    output dmem_ack
  );
endinterface

// File: rtl/multicycle_sequencer.sv
// Multi-cycle control FSM for the 8-bit core: fetch/decode/exec/mem/wb phases.
// Optional SEQ_SINGLE_STEP_EN adds a PAUSE state after every retire, left on step.
module multicycle_sequencer #(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 15,
  parameter int TO_W        = 4
) (
  input  logic                   CLK,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic                   halt_req,
  input  logic [2:0]             opcode,
  input  logic                   branch_taken,
  input  logic                   step,
  multicycle_sequencer_if.master dmem,
  output logic                   pc_clr,
  output logic                   ir_load,
  output logic                   pc_inc,
  output logic                   pc_branch,
  output logic                   reg_we,
  output logic                   busy,
  output logic                   done,
  output logic                   fault,
  output logic [CNT_W-1:0]       instr_count
);

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    FETCH  = 4'd1,
    DECODE = 4'd2,
    EXEC   = 4'd3,
    MEM    = 4'd4,
    WB     = 4'd5,
    DONE   = 4'd6,
`ifdef SEQ_SINGLE_STEP_EN
    PAUSE  = 4'd8,
`endif
    FAULT  = 4'd7
  } state_t;

  localparam logic [2:0]      OP_SB   = 3'd0;
  localparam logic [2:0]      OP_LB   = 3'd1;
  localparam logic [2:0]      OP_BNE  = 3'd7;
  localparam logic [TO_W-1:0] TIMEOUT = TO_W'(MEM_TIMEOUT);

  state_t          state, state_nxt;
  logic [TO_W-1:0] wait_cnt;
  logic            retire;
  logic            cnt_clr;
  logic            wait_clr;
  logic            wait_inc;

`ifdef SEQ_SINGLE_STEP_EN
  logic            halt_lat;
`else
  logic            unused_step;
  assign unused_step = step;
`endif

  always_comb begin
    state_nxt     = state;
    pc_clr        = 1'b0;
    ir_load       = 1'b0;
    pc_inc        = 1'b0;
    pc_branch     = 1'b0;
    reg_we        = 1'b0;
    dmem.dmem_req = 1'b0;
    dmem.dmem_we  = 1'b0;
    retire        = 1'b0;
    cnt_clr       = 1'b0;
    wait_clr      = 1'b0;
    wait_inc      = 1'b0;

    case (state)
      IDLE, DONE: begin
        if (start) begin
          pc_clr    = 1'b1;
          cnt_clr   = 1'b1;
          state_nxt = FETCH;
        end
      end
      FETCH: begin
        ir_load   = 1'b1;
        state_nxt = DECODE;
      end
      DECODE: state_nxt = EXEC;
      EXEC: begin
        if (opcode == OP_SB || opcode == OP_LB) begin
          wait_clr  = 1'b1;
          state_nxt = MEM;
        end else if (opcode == OP_BNE) begin
          pc_branch = branch_taken;
          pc_inc    = !branch_taken;
          retire    = 1'b1;
        end else begin
          state_nxt = WB;
        end
      end
      MEM: begin
        dmem.dmem_req = 1'b1;
        dmem.dmem_we  = (opcode == OP_SB);
        // An ack on the final allowed cycle still completes the access.
        if (dmem.dmem_ack) begin
          if (opcode == OP_SB) begin
            pc_inc = 1'b1;
            retire = 1'b1;
          end else begin
            state_nxt = WB;
          end
        end else if (wait_cnt + TO_W'(1) == TIMEOUT) begin
          state_nxt = FAULT;
        end else begin
          wait_inc = 1'b1;
        end
      end
      WB: begin
        reg_we = 1'b1;
        pc_inc = 1'b1;
        retire = 1'b1;
      end
      FAULT: state_nxt = FAULT;
`ifdef SEQ_SINGLE_STEP_EN
      PAUSE: begin
        if (step) state_nxt = halt_lat ? DONE : FETCH;
      end
`endif
      default: state_nxt = IDLE;
    endcase

    if (retire) begin
`ifdef SEQ_SINGLE_STEP_EN
      state_nxt = PAUSE;
`else
      state_nxt = halt_req ? DONE : FETCH;
`endif
    end
  end

  always_comb begin
    busy  = (state == FETCH) || (state == DECODE) || (state == EXEC) ||
            (state == MEM) || (state == WB);
`ifdef SEQ_SINGLE_STEP_EN
    busy  = busy || (state == PAUSE);
`endif
    done  = (state == DONE);
    fault = (state == FAULT);
  end

  always_ff @(posedge CLK) begin
    if (!reset_n) begin
      state       <= IDLE;
      instr_count <= '0;
      wait_cnt    <= '0;
    end else begin
      state <= state_nxt;
      if (cnt_clr)     instr_count <= '0;
      else if (retire) instr_count <= instr_count + CNT_W'(1);
      if (wait_clr)      wait_cnt <= '0;
      else if (wait_inc) wait_cnt <= wait_cnt + TO_W'(1);
    end
  end

`ifdef SEQ_SINGLE_STEP_EN
  // Halt is only sampled at retire, so it must survive the pause.
  always_ff @(posedge CLK) begin
    if (!reset_n)    halt_lat <= 1'b0;
    else if (retire) halt_lat <= halt_req;
  end
`endif

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Scoreboard bench for multicycle_sequencer: stimulus queues expected strobe
// events with their cycle numbers; a monitor pops and compares each DUT event.
module tb_multicycle_sequencer;

  localparam int CNT_W = 16;

  localparam logic [6:0] S_CLR = 7'b1000000;
  localparam logic [6:0] S_IR  = 7'b0100000;
  localparam logic [6:0] S_INC = 7'b0010000;
  localparam logic [6:0] S_BR  = 7'b0001000;
  localparam logic [6:0] S_RWE = 7'b0000100;
  localparam logic [6:0] S_REQ = 7'b0000010;
  localparam logic [6:0] S_DWE = 7'b0000001;

  typedef struct {
    int               cyc;
    logic [6:0]       strb;
    logic             busy;
    logic             done;
    logic             fault;
    logic [CNT_W-1:0] cnt;
  } ev_t;

  logic             CLK = 1'b0;
  logic             reset_n;
  logic             start;
  logic             halt_req;
  logic [2:0]       opcode;
  logic             branch_taken;
  logic             step;
  logic             pc_clr, ir_load, pc_inc, pc_branch, reg_we;
  logic             busy, done, fault;
  logic [CNT_W-1:0] instr_count;

  multicycle_sequencer_if dmem_if();

  multicycle_sequencer #(.CNT_W(CNT_W), .MEM_TIMEOUT(15), .TO_W(4)) dut (
    .CLK          (CLK),
    .reset_n      (reset_n),
    .start        (start),
    .halt_req     (halt_req),
    .opcode       (opcode),
    .branch_taken (branch_taken),
    .step         (step),
    .dmem         (dmem_if),
    .pc_clr       (pc_clr),
    .ir_load      (ir_load),
    .pc_inc       (pc_inc),
    .pc_branch    (pc_branch),
    .reg_we       (reg_we),
    .busy         (busy),
    .done         (done),
    .fault        (fault),
    .instr_count  (instr_count)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int  errors = 0;
  int  checks = 0;
  bit  mon_en = 1'b0;
  ev_t exp_q[$];

  wire [6:0] strb = {pc_clr, ir_load, pc_inc, pc_branch, reg_we,
                     dmem_if.dmem_req, dmem_if.dmem_we};

  task automatic expect_ev(input int c, input logic [6:0] s, input logic b,
                           input logic d, input logic f, input logic [CNT_W-1:0] n);
    ev_t e;
    e.cyc = c; e.strb = s; e.busy = b; e.done = d; e.fault = f; e.cnt = n;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, req);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) tick();
  endtask

  // Monitor: an event is any active strobe or a rising edge of done/fault.
  initial begin : monitor
    logic done_q, fault_q;
    ev_t  e;
    done_q  = 1'b0;
    fault_q = 1'b0;
    forever begin
      @(negedge CLK);
      if (mon_en && (strb != 7'd0 || (done && !done_q) || (fault && !fault_q))) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event cyc=%0d actual strb=%b busy=%b done=%b fault=%b cnt=%0d required none",
                   cyc, strb, busy, done, fault, instr_count);
        end else begin
          e = exp_q.pop_front();
          if (e.cyc != cyc || e.strb !== strb || e.busy !== busy || e.done !== done ||
              e.fault !== fault || e.cnt !== instr_count) begin
            errors++;
            $display("FAIL event cyc=%0d strb=%b busy=%b done=%b fault=%b cnt=%0d required cyc=%0d strb=%b busy=%b done=%b fault=%b cnt=%0d",
                     cyc, strb, busy, done, fault, instr_count,
                     e.cyc, e.strb, e.busy, e.done, e.fault, e.cnt);
          end
        end
      end
      done_q  = done;
      fault_q = fault;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int b;
    reset_n = 1'b0; start = 1'b0; halt_req = 1'b0; opcode = 3'd0;
    branch_taken = 1'b0; step = 1'b0; dmem_if.dmem_ack = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    @(negedge CLK);
    chk("reset_strobes", 32'(strb), 32'd0);
    chk("reset_busy",    32'(busy), 32'd0);
    chk("reset_done",    32'(done), 32'd0);
    chk("reset_fault",   32'(fault), 32'd0);
    chk("reset_count",   32'(instr_count), 32'd0);
    mon_en = 1'b1;
    tick();

    // Three adds, halt on the third retire.
    b = cyc;
    expect_ev(b,      S_CLR,         0, 0, 0, 0);
    expect_ev(b + 1,  S_IR,          1, 0, 0, 0);
    expect_ev(b + 4,  S_RWE | S_INC, 1, 0, 0, 0);
    expect_ev(b + 5,  S_IR,          1, 0, 0, 1);
    expect_ev(b + 8,  S_RWE | S_INC, 1, 0, 0, 1);
    expect_ev(b + 9,  S_IR,          1, 0, 0, 2);
    expect_ev(b + 12, S_RWE | S_INC, 1, 0, 0, 2);
    expect_ev(b + 13, 7'd0,          0, 1, 0, 3);
    opcode = 3'd2; start = 1'b1;
    tick(); start = 1'b0;
    wait_to(b + 9);  halt_req = 1'b1;
    wait_to(b + 13); halt_req = 1'b0;
    wait_to(b + 14);

    // bne taken, then not taken with halt.
    b = cyc;
    expect_ev(b,     S_CLR, 0, 1, 0, 3);
    expect_ev(b + 1, S_IR,  1, 0, 0, 0);
    expect_ev(b + 3, S_BR,  1, 0, 0, 0);
    expect_ev(b + 4, S_IR,  1, 0, 0, 1);
    expect_ev(b + 6, S_INC, 1, 0, 0, 1);
    expect_ev(b + 7, 7'd0,  0, 1, 0, 2);
    opcode = 3'd7; branch_taken = 1'b1; start = 1'b1;
    tick(); start = 1'b0;
    wait_to(b + 4); branch_taken = 1'b0;
    wait_to(b + 6); halt_req = 1'b1;
    wait_to(b + 7); halt_req = 1'b0;
    wait_to(b + 8);

    // lb with ack after three wait cycles; a stray ack in DECODE is ignored.
    b = cyc;
    expect_ev(b,     S_CLR, 0, 1, 0, 2);
    expect_ev(b + 1, S_IR,  1, 0, 0, 0);
    for (int k = 4; k <= 7; k++) expect_ev(b + k, S_REQ, 1, 0, 0, 0);
    expect_ev(b + 8, S_RWE | S_INC, 1, 0, 0, 0);
    expect_ev(b + 9, 7'd0,          0, 1, 0, 1);
    opcode = 3'd1; start = 1'b1;
    tick(); start = 1'b0;
    wait_to(b + 2); dmem_if.dmem_ack = 1'b1;
    tick();         dmem_if.dmem_ack = 1'b0;
    wait_to(b + 7); dmem_if.dmem_ack = 1'b1;
    tick();         dmem_if.dmem_ack = 1'b0; halt_req = 1'b1;
    tick();         halt_req = 1'b0;
    wait_to(b + 10);

    // sb acked on the 15th MEM cycle, then an sb that times out.
    b = cyc;
    expect_ev(b,     S_CLR, 0, 1, 0, 1);
    expect_ev(b + 1, S_IR,  1, 0, 0, 0);
    for (int k = 4; k <= 17; k++) expect_ev(b + k, S_REQ | S_DWE, 1, 0, 0, 0);
    expect_ev(b + 18, S_REQ | S_DWE | S_INC, 1, 0, 0, 0);
    expect_ev(b + 19, S_IR, 1, 0, 0, 1);
    for (int k = 22; k <= 36; k++) expect_ev(b + k, S_REQ | S_DWE, 1, 0, 0, 1);
    expect_ev(b + 37, 7'd0, 0, 0, 1, 1);
    opcode = 3'd0; start = 1'b1;
    tick(); start = 1'b0;
    wait_to(b + 18); dmem_if.dmem_ack = 1'b1;
    tick();          dmem_if.dmem_ack = 1'b0;
    wait_to(b + 38); start = 1'b1;
    @(negedge CLK);
    chk("fault_start_pc_clr", 32'(pc_clr), 32'd0);
    tick(); start = 1'b0;
    @(negedge CLK);
    chk("fault_sticky", 32'(fault), 32'd1);
    chk("fault_busy",   32'(busy),  32'd0);
    tick(); reset_n = 1'b0;
    tick(); reset_n = 1'b1;
    @(negedge CLK);
    chk("fault_reset_fault", 32'(fault), 32'd0);
    chk("fault_reset_count", 32'(instr_count), 32'd0);
    chk("fault_reset_done",  32'(done), 32'd0);
    tick();

    // Start held into FETCH is ignored; reset during MEM aborts the load.
    b = cyc;
    expect_ev(b,     S_CLR,         0, 0, 0, 0);
    expect_ev(b + 1, S_IR,          1, 0, 0, 0);
    expect_ev(b + 4, S_RWE | S_INC, 1, 0, 0, 0);
    expect_ev(b + 5, S_IR,          1, 0, 0, 1);
    expect_ev(b + 8, S_REQ,         1, 0, 0, 1);
    expect_ev(b + 9, S_REQ,         1, 0, 0, 1);
    opcode = 3'd2; start = 1'b1;
    tick();
    tick(); start = 1'b0;
    wait_to(b + 5); opcode = 3'd1; start = 1'b1;
    tick(); start = 1'b0;
    wait_to(b + 9); reset_n = 1'b0;
    tick(); reset_n = 1'b1;
    @(negedge CLK);
    chk("abort_dmem_req", 32'(dmem_if.dmem_req), 32'd0);
    chk("abort_busy",     32'(busy), 32'd0);
    chk("abort_count",    32'(instr_count), 32'd0);
    tick();

`ifdef SEQ_SINGLE_STEP_EN
    // Single-step: pause after each retire, halt carried through the pause.
    b = cyc;
    expect_ev(b,      S_CLR,         0, 0, 0, 0);
    expect_ev(b + 1,  S_IR,          1, 0, 0, 0);
    expect_ev(b + 4,  S_RWE | S_INC, 1, 0, 0, 0);
    expect_ev(b + 8,  S_IR,          1, 0, 0, 1);
    expect_ev(b + 11, S_RWE | S_INC, 1, 0, 0, 1);
    expect_ev(b + 14, 7'd0,          0, 1, 0, 2);
    opcode = 3'd3; start = 1'b1;
    tick(); start = 1'b0;
    wait_to(b + 6);
    @(negedge CLK);
    chk("pause_busy", 32'(busy), 32'd1);
    wait_to(b + 7);  step = 1'b1;
    tick();          step = 1'b0;
    wait_to(b + 11); halt_req = 1'b1;
    tick();          halt_req = 1'b0;
    wait_to(b + 13); step = 1'b1;
    tick();          step = 1'b0;
    wait_to(b + 15);
`endif

    repeat (3) tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_events actual=%0d pending required=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
